// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, data width, bit-period helper.
package uart_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   // Integer truncation is intentional; the receiver uses the same rounding.
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous circular-buffer FIFO; combinational head read, registered count.
// Simultaneous push/pop leaves the count unchanged; the caller never pushes when full.
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   assign pop_data = mem[rd_ptr];
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter, start bit 2 cycles after accept; TxReady low while FIFO full.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int BAUD_RATE   = 115200,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic [7:0]                    TxData,
   input  logic                          TxValid,
   output logic                          TxReady,
   output logic                          Tx,
   output logic                          Busy,
   output logic [$clog2(FIFO_DEPTH):0]   FifoCount
);

   localparam int CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
   localparam int CNT_W = $clog2(CPB);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CPB - 1);

   tx_state_t          state;
   tx_state_t          state_nxt;
   logic [CNT_W-1:0]   baud_cnt;
   logic [CNT_W-1:0]   baud_nxt;
   logic [2:0]         bit_idx;
   logic [2:0]         idx_nxt;
   logic [DATA_W-1:0]  shift;
   logic [DATA_W-1:0]  shift_nxt;
   logic [DATA_W-1:0]  head;
   logic               tx_nxt;
   logic               push;
   logic               pop;
   logic               full;
   logic               empty;
   logic               bit_end;

   assign push    = TxValid && TxReady;
   assign TxReady = !full;
   assign Busy    = (state != ST_IDLE) || !empty;
   assign bit_end = (baud_cnt == BIT_LAST);

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk       (Clk),
      .reset     (Reset),
      .push      (push),
      .push_data (TxData),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty),
      .count     (FifoCount)
   );

`ifdef UART_TX_PARITY_EN
   logic parity_bit;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         parity_bit <= 1'b0;
      end else if (pop) begin
         parity_bit <= ^head;
      end
   end
`endif

   // Tx is registered from the current state, so the line trails the FSM by one cycle.
   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt;
      idx_nxt   = bit_idx;
      shift_nxt = shift;
      pop       = 1'b0;
      tx_nxt    = 1'b1;
      if (state != ST_IDLE) begin
         baud_nxt = bit_end ? '0 : baud_cnt + 1'b1;
      end
      case (state)
         ST_IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               shift_nxt = head;
               baud_nxt  = '0;
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            tx_nxt = 1'b0;
            if (bit_end) begin
               idx_nxt   = '0;
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            tx_nxt = shift[0];
            if (bit_end) begin
               shift_nxt = shift >> 1;
               idx_nxt   = bit_idx + 1'b1;
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_nxt = ST_PARITY;
`else
                  state_nxt = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            tx_nxt = parity_bit;
            if (bit_end) begin
               state_nxt = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (bit_end) begin
               if (!empty) begin
                  pop       = 1'b1;
                  shift_nxt = head;
                  state_nxt = ST_START;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         Tx       <= 1'b1;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_idx  <= idx_nxt;
         shift    <= shift_nxt;
         Tx       <= tx_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: scoreboard of accepted bytes against a mid-bit sampling line receiver.
module tb_uart_tx_buffered;

   localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int FRAME = FB * CPB;

   logic       Clk;
   logic       Reset;
   logic [7:0] TxData;
   logic       TxValid;
   logic       TxReady;
   logic       Tx;
   logic       Busy;
   logic [2:0] FifoCount;

   uart_tx_buffered #(
      .CLK_FREQ_HZ (1600),
      .BAUD_RATE   (100),
      .FIFO_DEPTH  (4)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .TxData    (TxData),
      .TxValid   (TxValid),
      .TxReady   (TxReady),
      .Tx        (Tx),
      .Busy      (Busy),
      .FifoCount (FifoCount)
   );

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [7:0] exp_q[$];
   int         starts[$];
   logic       pars[$];
   int         frames_done = 0;

   bit         mon_active = 0;
   int         mon_s;
   int         d;
   int         k;
   logic [7:0] rx;
   logic       rx_par;
   logic [7:0] eb;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp_v, cyc);
      end
   endtask

   // Line receiver: frame starts at the first low sample, each bit sampled mid-period.
   always @(negedge Clk) begin
      if (Reset) begin
         mon_active = 0;
      end else if (!mon_active) begin
         if (Tx === 1'b0) begin
            mon_active = 1;
            mon_s = cyc;
            starts.push_back(cyc);
         end
      end else begin
         d = cyc - mon_s;
         if (d % CPB == CPB / 2) begin
            k = d / CPB;
            if (k == 0) chk("start_bit", int'(Tx), 0);
            else if (k <= 8) rx[k-1] = Tx;
            else if (k == 9 && FB == 11) rx_par = Tx;
            if (k == FB - 1) begin
               chk("stop_bit", int'(Tx), 1);
               if (exp_q.size() == 0) begin
                  chk("unexpected_frame", int'(rx), -1);
               end else begin
                  eb = exp_q.pop_front();
                  chk("frame_data", int'(rx), int'(eb));
                  if (FB == 11) begin
                     pars.push_back(rx_par);
                     chk("parity_bit", int'(rx_par), $countones(eb) % 2);
                  end
               end
               frames_done++;
               mon_active = 0;
            end
         end
      end
   end

   task automatic send(input logic [7:0] b, output int edge_e);
      bit got = 0;
      edge_e = -1;
      TxData  = b;
      TxValid = 1'b1;
      for (int i = 0; i < 2000 && !got; i++) begin
         @(negedge Clk);
         if (TxReady) begin
            exp_q.push_back(b);
            edge_e = cyc + 1;
            got = 1;
         end
         @(posedge Clk);
         #1;
      end
      TxValid = 1'b0;
      if (!got) chk("send_timeout", 0, 1);
   endtask

   task automatic drain(input string name);
      int ok = 0;
      for (int i = 0; i < 8000; i++) begin
         @(negedge Clk);
         if (!Busy && !mon_active && exp_q.size() == 0) begin
            ok = 1;
            break;
         end
      end
      chk(name, ok, 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: bench exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e;
      int e1;
      int e6;
      int n;
      int snap;
      int sz;
      int bad;
      int gap;
      logic [7:0] v;

      Reset   = 1'b1;
      TxValid = 1'b0;
      TxData  = 8'h00;
      repeat (3) @(posedge Clk);
      #1;
      Reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 100; i++) begin
         @(negedge Clk);
         chk("idle_tx", int'(Tx), 1);
         chk("idle_busy", int'(Busy), 0);
         chk("idle_ready", int'(TxReady), 1);
         chk("idle_count", int'(FifoCount), 0);
      end
      @(posedge Clk);
      #1;

      // Single byte: latency, frame timing, Busy release
      starts.delete();
      send(8'hA5, e);
      for (int i = 0; i < 400 && cyc < e + FRAME; i++) @(negedge Clk);
      chk("a5_busy_in_stop", int'(Busy), 1);
      for (int i = 0; i < 10 && cyc < e + FRAME + 2; i++) @(negedge Clk);
      chk("a5_busy_done", int'(Busy), 0);
      drain("a5_drain");
      chk("a5_frames", starts.size(), 1);
      chk("a5_start_latency", (starts.size() > 0) ? starts[0] : -1, e + 2);
      @(posedge Clk);
      #1;

      // Random bytes with random gaps
      for (int i = 0; i < 12; i++) begin
         send(8'($urandom_range(0, 255)), e);
         gap = ($urandom_range(0, 2) == 0) ? $urandom_range(50, 250) : 0;
         if (gap > 0) begin
            repeat (gap) @(posedge Clk);
            #1;
         end
      end
      drain("rand_drain");
      @(posedge Clk);
      #1;

      // Held TxValid, incrementing data: fill, stall, back-to-back frames
      starts.delete();
      v = 8'h01;
      n = 0;
      e1 = -1;
      e6 = -1;
      TxData  = v;
      TxValid = 1'b1;
      for (int i = 0; i < 3000 && n < 6; i++) begin
         bit acc = 0;
         @(negedge Clk);
         if (n == 5 && e6 == -1 && cyc == e1 + 4) begin
            chk("full_ready_low", int'(TxReady), 0);
            chk("full_count", int'(FifoCount), 4);
         end
         if (TxReady) begin
            exp_q.push_back(v);
            if (n == 0) e1 = cyc + 1;
            if (n == 5) e6 = cyc + 1;
            n++;
            acc = 1;
         end
         @(posedge Clk);
         #1;
         if (acc) begin
            v = v + 8'd1;
            TxData = v;
         end
      end
      TxValid = 1'b0;
      chk("b2b_accepted", n, 6);
      chk("full_accept_edge", e6, e1 + FRAME + 2);
      drain("b2b_drain");
      chk("b2b_frames", starts.size(), 6);
      for (int i = 1; i < 6 && i < starts.size(); i++) begin
         chk("b2b_spacing", starts[i] - starts[i-1], FRAME);
      end
      @(posedge Clk);
      #1;

`ifdef UART_TX_PARITY_EN
      starts.delete();
      pars.delete();
      send(8'h07, e);
      send(8'h03, e);
      drain("par_drain");
      chk("par_07", (pars.size() > 0) ? int'(pars[0]) : -1, 1);
      chk("par_03", (pars.size() > 1) ? int'(pars[1]) : -1, 0);
      chk("par_spacing", (starts.size() > 1) ? starts[1] - starts[0] : -1, 176);
      @(posedge Clk);
      #1;
`endif

      // Reset mid-DATA with two bytes queued
      starts.delete();
      send(8'h3C, e);
      send(8'h11, e);
      send(8'h22, e);
      for (int i = 0; i < 2000 && !(starts.size() > 0 && cyc >= starts[0] + 4 * CPB); i++)
         @(negedge Clk);
      @(posedge Clk);
      #1;
      Reset = 1'b1;
      exp_q.delete();
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      @(negedge Clk);
      chk("rst_tx", int'(Tx), 1);
      chk("rst_count", int'(FifoCount), 0);
      chk("rst_busy", int'(Busy), 0);
      chk("rst_ready", int'(TxReady), 1);
      snap = frames_done;
      sz = starts.size();
      bad = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge Clk);
         if (Tx !== 1'b1 || Busy !== 1'b0) bad++;
      end
      chk("rst_line_quiet", bad, 0);
      chk("rst_no_frames", frames_done, snap);
      chk("rst_no_starts", starts.size(), sz);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Byte-oriented UART transmitter: 8N1 framing, LSB first, idle-high line.
- Accepts bytes over a valid/ready handshake into a small FIFO, then serialises them back-to-back on Tx.
- Transmit-side counterpart to the UART receiver. Sits beside it in the UART top level, driven by user logic that produces bytes.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency.
- BAUD_RATE, 115200, line rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE with integer truncation (868 at defaults); must be >= 2.
- FIFO_DEPTH, 4, byte slots; power of two, >= 2.

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- TxData  input  8  byte to send.
- TxValid  input  1  TxData is valid.
- TxReady  output  1  FIFO can accept a byte.
- Tx  output  1  serial line, registered.
- Busy  output  1  frame in progress or FIFO non-empty.
- FifoCount  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered.

Behaviour:
- Clocking/reset (already decided): one clock, Clk; reset is synchronous and active-high on Reset.
- Reset values: Tx=1, TxReady=1, Busy=0, FifoCount=0, FSM=IDLE, baud counter=0, bit index=0, FIFO pointers=0.
- Handshake:
  - TxReady = (FifoCount != FIFO_DEPTH), combinational from registered count.
  - A byte is accepted on an edge where TxValid && TxReady.
  - TxData is sampled only on that edge.
  - No bypass: a pop freeing a full FIFO raises TxReady only on the following cycle.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - Push and pop on the same edge leave FifoCount unchanged.
  - Push when full is impossible by construction.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: Tx=1. If FifoCount != 0, pop the head into the shift register, clear the baud counter, go to START.
  - START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: Tx = shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. After bit 7, go to STOP.
  - STOP: Tx=1 for CLKS_PER_BIT cycles. Then go to IDLE, or straight to START if FifoCount != 0 (pop on the same edge), so consecutive frames have no idle gap.
- Baud counter: counts 0..CLKS_PER_BIT-1; a bit boundary occurs at terminal count. Width is $clog2(CLKS_PER_BIT).
- Latency:
  - Accept edge E with FSM idle and FIFO empty: Tx goes low on edge E+2, i.e. FifoCount=1 becomes visible at E+1 and the pop happens at E+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- Busy = (state != IDLE) || (FifoCount != 0).
- Reset mid-frame: on the next edge Tx=1, the frame is abandoned, the FIFO is flushed, and no partial retransmission occurs.
- TxValid with TxReady low: stall. The source holds TxData and TxValid; the block never drops an accepted byte.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame length becomes 11*CLKS_PER_BIT.
- When undefined: no PARITY state and no parity logic; frames are 8N1.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP);
  - data width constant 8;
  - a CLKS_PER_BIT helper function, shared with the receiver.
- One sub-module, uart_tx_fifo: parameterised sync FIFO with push/pop/full/empty/count. The top holds the FSM and baud counter.

Test Plan (simulation with CLK_FREQ_HZ=1600, BAUD_RATE=100, so CLKS_PER_BIT=16):
- Reset, then idle 100 cycles -> Tx=1, Busy=0, TxReady=1, FifoCount=0 throughout.
- Push 0xA5 at edge E -> Tx low at E+2 for 16 cycles. Then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then 16 cycles high. Busy drops at E+162.
- Hold TxValid high with 0x01..0x06 incrementing on each accept -> TxReady low after 4 buffered bytes plus 1 in flight. All 6 bytes appear back-to-back, 160 cycles per frame, no gaps, in order.
- Assert Reset for 1 cycle mid-DATA of byte 0x3C with 2 bytes queued -> Tx=1 on the next edge, FifoCount=0, Busy=0; no further frames appear.
- With UART_TX_PARITY_EN, send 0x07 -> a parity bit of 1 follows bit 7; frame spans 176 cycles. Send 0x03 -> parity bit 0.
- Push while FifoCount=4 with TxValid high -> no acceptance until the pop edge plus 1 cycle; the byte is then captured exactly once.
